// File: rtl/mux4_pkg.sv
// Shared types and constants for the 4:1 mux channel scanner.
package mux4_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;

   localparam int unsigned DWELL_MAX = 255;

   // A dwell of 1 still needs a one-bit counter so term has something to compare.
   function automatic int unsigned cnt_width(input int unsigned dwell);
      return (dwell > 1) ? $clog2(dwell) : 1;
   endfunction

endpackage

// File: rtl/mux4_dwell_cnt.sv
// Dwell up-counter: counts while enabled, clears on request, flags DWELL-1.
module mux4_dwell_cnt #(
   parameter int unsigned DWELL = 2,
   parameter int unsigned CW    = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic term_o
);

   localparam logic [CW-1:0] TERM = CW'(DWELL - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/mux4_scanner.sv
// Steps the mux select through channels 0..3, samples Y after each dwell,
// and publishes the four samples together with a one-cycle DONE pulse.
module mux4_scanner
   import mux4_pkg::*;
#(
   parameter int unsigned DWELL = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       START,
   input  logic       CONT,
   input  logic       Y,
   output logic       S0,
   output logic       S1,
   output logic       BUSY,
   output logic       DONE,
   output logic [3:0] Q
);

   localparam int unsigned CW = cnt_width(DWELL);

   state_e     state_q, state_d;
   logic [1:0] chan_q, chan_d;
   logic [2:0] shadow_q;
   logic [3:0] q_q;
   logic       done_q;
   logic       term;
   logic       cnt_clr;
   logic       cnt_en;
   logic       sample;
   logic       last;

   assign sample  = (state_q == SCAN) && term;
   assign last    = sample && (chan_q == CH_D);
   assign cnt_en  = (state_q == SCAN);
   assign cnt_clr = (state_q == IDLE) || term;

   mux4_dwell_cnt #(
      .DWELL (DWELL),
      .CW    (CW)
   ) u_dwell (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .term_o (term)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         chan_q  <= CH_A;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
      end
   end

   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      case (state_q)
         IDLE: begin
            chan_d = CH_A;
            if (START) begin
               state_d = SCAN;
            end
         end
         SCAN: begin
            // Channel wraps 3->0 on its own at scan completion.
            if (term) begin
               chan_d = chan_q + 2'd1;
            end
            if (last && !CONT) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            chan_d  = CH_A;
         end
      endcase
   end

   always_comb begin
      BUSY     = (state_q == SCAN);
      {S1, S0} = chan_q;
      DONE     = done_q;
      Q        = q_q;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         shadow_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sample && (chan_q == 2'(i))) begin
               shadow_q[i] <= Y;
            end
         end
      end
   end

   // Channel 3 bypasses the shadow so Q is loaded whole on the final sample.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q_q    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= last;
         if (last) begin
            q_q <= {Y, shadow_q};
         end
      end
   end

endmodule

// File: tb/tb_mux4_scanner.sv
// Directed bench: scanner driving a behavioural 4:1 mux, DWELL = 2.
module tb_mux4_scanner;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       cont;
   logic [3:0] din;
   logic       y;
   logic       s0;
   logic       s1;
   logic       busy;
   logic       done;
   logic [3:0] q;

   int         errors;
   int         checks;
   logic [3:0] prev_q;
   logic [3:0] ctl_e;
   logic [3:0] q_e;
   int         ph;

   assign y = din[{s1, s0}];

   mux4_scanner #(.DWELL(2)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .START (start),
      .CONT  (cont),
      .Y     (y),
      .S0    (s0),
      .S1    (s1),
      .BUSY  (busy),
      .DONE  (done),
      .Q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int n, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
      end
   endtask

   // One scan with CONT=0: ctl = {S1,S0,BUSY,DONE}, n counts edges after START edge.
   task automatic scan(input logic [3:0] dcba, input bit glitch, input bit restart, input string tag);
      din   = dcba;
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, ".ctl"}, 0, {s1, s0, busy, done}, 4'b0010);
      for (int n = 1; n <= 11; n++) begin
         step();
         din   = dcba;
         start = 1'b0;
         if (n < 8) begin
            chk({tag, ".ctl"}, n, {s1, s0, busy, done}, {2'(n / 2), 2'b10});
            chk({tag, ".q"}, n, q, prev_q);
         end else if (n == 8) begin
            chk({tag, ".ctl"}, n, {s1, s0, busy, done}, 4'b0001);
            chk({tag, ".q"}, n, q, dcba);
         end else begin
            chk({tag, ".ctl"}, n, {s1, s0, busy, done}, 4'b0000);
            chk({tag, ".q"}, n, q, dcba);
         end
         if (glitch && n < 8 && (n % 2) == 1) begin
            din = dcba ^ (4'b0001 << (((n / 2) + 1) % 4));
         end
         if (restart && (n == 3 || n == 5)) begin
            start = 1'b1;
         end
      end
      prev_q = dcba;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      prev_q = 4'b0000;
      rst_n  = 1'b1;
      start  = 1'b0;
      cont   = 1'b0;
      din    = 4'b0000;

      #2 rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst.ctl", k, {s1, s0, busy, done}, 4'b0000);
         chk("rst.q", k, q, 4'b0000);
      end
      rst_n = 1'b1;
      din   = 4'b1111;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("idle.ctl", k, {s1, s0, busy, done}, 4'b0000);
         chk("idle.q", k, q, 4'b0000);
      end

      scan(4'b1010, 1'b0, 1'b0, "single");

      scan(4'b0001, 1'b1, 1'b0, "onehotA");
      scan(4'b0010, 1'b1, 1'b0, "onehotB");
      scan(4'b0100, 1'b1, 1'b0, "onehotC");
      scan(4'b1000, 1'b1, 1'b0, "onehotD");

      din   = 4'b1001;
      cont  = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("cont.ctl", 0, {s1, s0, busy, done}, 4'b0010);
      for (int n = 1; n <= 30; n++) begin
         step();
         if (n <= 24) begin
            ph    = n % 8;
            ctl_e = {2'(ph / 2), 1'(n != 24), 1'(ph == 0)};
         end else begin
            ctl_e = 4'b0000;
         end
         if (n < 8)       q_e = prev_q;
         else if (n < 16) q_e = 4'b1001;
         else if (n < 24) q_e = 4'b0110;
         else             q_e = 4'b1100;
         chk("cont.ctl", n, {s1, s0, busy, done}, ctl_e);
         chk("cont.q", n, q, q_e);
         if (n == 8)  din  = 4'b0110;
         if (n == 16) din  = 4'b1100;
         if (n == 20) cont = 1'b0;
      end
      prev_q = 4'b1100;

      scan(4'b0101, 1'b0, 1'b1, "restart");

      din   = 4'b0011;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         step();
         chk("abort.ctl", n, {s1, s0, busy, done}, {2'(n / 2), 2'b10});
      end
      rst_n = 1'b0;
      #1;
      chk("abort.ctl", 4, {s1, s0, busy, done}, 4'b0000);
      chk("abort.q", 4, q, 4'b0000);
      for (int k = 0; k < 2; k++) begin
         step();
         chk("abort.rst.ctl", k, {s1, s0, busy, done}, 4'b0000);
         chk("abort.rst.q", k, q, 4'b0000);
      end
      rst_n  = 1'b1;
      prev_q = 4'b0000;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("abort.idle.ctl", k, {s1, s0, busy, done}, 4'b0000);
         chk("abort.idle.q", k, q, 4'b0000);
      end
      scan(4'b0011, 1'b0, 1'b0, "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
